// File: rtl/neuron_pkg.sv
// Shared types for the neuron datapath: sample type, sequencer states and the ReLU helper.
package neuron_pkg;

   localparam int unsigned DATA_W = 8;

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      CAPTURE,
      OUT
   } seq_state_t;

   // Sign-bit test only; the result never saturates.
   function automatic data_t relu(data_t v);
      return v[DATA_W-1] ? '0 : v;
   endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Sample input stream and result output stream of the MAC sequencer (valid/ready both ways).
interface mac_sequencer_if;
   import neuron_pkg::*;

   logic  in_valid;
   data_t in_data;
   logic  in_ready;
   logic  out_valid;
   data_t out_data;
   logic  out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/weight_regfile.sv
// Weight and bias registers: entries 0..N_INPUTS-1 are weights, entry N_INPUTS is the bias.
module weight_regfile
   import neuron_pkg::*;
#(
   parameter int unsigned N_INPUTS = 4,
   parameter int unsigned ADDR_W   = $clog2(N_INPUTS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  data_t             wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output data_t             rdata_o,
   output data_t             bias_o
);

   data_t regs_q [N_INPUTS+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i <= N_INPUTS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i <= N_INPUTS; i++) begin
            if (we_i && (waddr_i == ADDR_W'(i))) begin
               regs_q[i] <= wdata_i;
            end
         end
      end
   end

   assign rdata_o = regs_q[raddr_i];
   assign bias_o  = regs_q[N_INPUTS];

endmodule

// File: rtl/mac_sequencer.sv
// Feeds one input vector into the multiply/accumulate stage, then returns ReLU of its result.
module mac_sequencer
   import neuron_pkg::*;
#(
   parameter int unsigned N_INPUTS = 4,
   parameter int unsigned ADDR_W   = $clog2(N_INPUTS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  data_t                 wr_data,
   output logic                  wr_err,
   mac_sequencer_if.slave        stream,
   output logic                  acc_clr,
   output logic                  en,
   output data_t                 x,
   output data_t                 weight,
   output data_t                 bias,
   input  data_t                 accu,
   output logic                  busy
);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              hs, wr_ok, wr_bad;
   data_t             rd_weight, rd_bias;

   logic  acc_clr_q, en_q, out_valid_q, busy_q, wr_err_q;
   data_t x_q, weight_q, bias_q, out_data_q;

   assign stream.in_ready = (state_q == FEED);
   assign hs              = stream.in_valid && stream.in_ready;
   assign wr_ok           = wr_en && (state_q == IDLE) && (wr_addr <= ADDR_W'(N_INPUTS));
   assign wr_bad          = wr_en && !wr_ok;

   weight_regfile #(
      .N_INPUTS (N_INPUTS),
      .ADDR_W   (ADDR_W)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_ok),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (idx_q),
      .rdata_o (rd_weight),
      .bias_o  (rd_bias)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         // A simultaneous register write takes priority over starting a vector.
         IDLE:    if (stream.in_valid && !wr_en) state_d = CLEAR;
         CLEAR: begin
            idx_d   = '0;
            state_d = FEED;
         end
         FEED: begin
            if (hs) begin
               if (idx_q == ADDR_W'(N_INPUTS - 1)) begin
                  state_d = DRAIN;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end
         end
         DRAIN:   state_d = CAPTURE;
         CAPTURE: state_d = OUT;
         OUT:     if (stream.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_clr_q   <= 1'b0;
         en_q        <= 1'b0;
         x_q         <= '0;
         weight_q    <= '0;
         bias_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_clr_q   <= (state_d == CLEAR);
         en_q        <= hs;
         // x/weight/bias hold between handshakes so the stage sees stable operands.
         if (hs) begin
            x_q      <= stream.in_data;
            weight_q <= rd_weight;
            bias_q   <= rd_bias;
         end
         if (state_q == CAPTURE) begin
            out_data_q <= relu(accu);
         end
         out_valid_q <= (state_d == OUT);
         busy_q      <= (state_d != IDLE);
         wr_err_q    <= wr_bad;
      end
   end

   assign acc_clr          = acc_clr_q;
   assign en               = en_q;
   assign x                = x_q;
   assign weight           = weight_q;
   assign bias             = bias_q;
   assign stream.out_valid = out_valid_q;
   assign stream.out_data  = out_data_q;
   assign busy             = busy_q;
   assign wr_err           = wr_err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised bench for mac_sequencer against a vector-level reference model.
module tb_mac_sequencer;
   import neuron_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   data_t         wr_data;
   logic          wr_err;
   logic          acc_clr, en, busy;
   data_t         x, weight, bias, accu;

   mac_sequencer_if ifc ();

   mac_sequencer #(
      .N_INPUTS (N)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_err  (wr_err),
      .stream  (ifc),
      .acc_clr (acc_clr),
      .en      (en),
      .x       (x),
      .weight  (weight),
      .bias    (bias),
      .accu    (accu),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: register file contents and per-vector progress.
   data_t w_m [N];
   data_t b_m;
   int    vec_idx;
   int    cyc;
   int    last_hs_cyc;
   int    acc_clr_cnt;
   logic  acc_clr_prev;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: predict from the inputs driven now, then check after the edge.
   task automatic step();
      logic  hs;
      data_t ex, ew, eb;
      hs = ifc.in_valid && ifc.in_ready;
      ex = ifc.in_data;
      ew = (vec_idx < N) ? w_m[vec_idx] : data_t'(0);
      eb = b_m;
      @(negedge clk);
      cyc++;
      check_eq("en", en, hs);
      if (hs) begin
         check_eq("x", x, ex);
         check_eq("weight", weight, ew);
         check_eq("bias", bias, eb);
         vec_idx++;
         last_hs_cyc = cyc - 1;
      end
      if (acc_clr_prev) check_eq("in_ready_after_clr", ifc.in_ready, 1'b1);
      if (acc_clr) begin
         acc_clr_cnt++;
         check_eq("in_ready_during_clr", ifc.in_ready, 1'b0);
      end
      acc_clr_prev = acc_clr;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, {ifc.in_ready, acc_clr, en, x, weight, bias, ifc.out_valid, ifc.out_data,
                     busy, wr_err}, 64'd0);
   endtask

   // Register write issued from IDLE; addresses above N must be rejected.
   task automatic wr(input int addr, input data_t d);
      bit ok;
      ok      = (addr <= N);
      wr_en   = 1'b1;
      wr_addr = AW'(addr);
      wr_data = d;
      step();
      wr_en = 1'b0;
      check_eq("wr_err", wr_err, !ok);
      if (ok) begin
         if (addr == N) b_m = d;
         else w_m[addr] = d;
      end
   endtask

   task automatic send_vector(input data_t v [N], input bit gap, input data_t acc_v,
                              input int hold, input bit inj_wr, input int abort_after);
      bit    tog, did_wr, inj_now;
      int    budget;
      data_t exp_o;
      vec_idx       = 0;
      acc_clr_cnt   = 0;
      accu          = acc_v;
      ifc.out_ready = 1'b0;
      tog           = 1'b1;
      did_wr        = 1'b0;
      inj_now       = 1'b0;
      budget        = 0;
      while (vec_idx < N && budget < 60) begin
         ifc.in_data  = v[vec_idx];
         ifc.in_valid = (gap && ifc.in_ready) ? tog : 1'b1;
         if (ifc.in_ready) tog = ~tog;
         if (inj_wr && vec_idx == 1 && !did_wr) begin
            wr_en   = 1'b1;
            wr_addr = AW'(1);
            wr_data = 8'sd9;
            did_wr  = 1'b1;
            inj_now = 1'b1;
         end
         step();
         if (inj_now) begin
            wr_en   = 1'b0;
            inj_now = 1'b0;
            check_eq("wr_err_in_feed", wr_err, 1'b1);
         end
         if (abort_after > 0 && vec_idx == abort_after) begin
            #2 rst_n = 1'b0;
            ifc.in_valid = 1'b0;
            #1 check_all_zero("reset_mid_feed");
            for (int i = 0; i < N; i++) w_m[i] = '0;
            b_m          = '0;
            acc_clr_prev = 1'b0;
            #2 rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         budget++;
      end
      check_eq("feed_complete", vec_idx, N);
      ifc.in_valid = 1'b0;
      budget = 0;
      while (!ifc.out_valid && budget < 10) begin
         step();
         budget++;
      end
      check_eq("out_valid_rise", ifc.out_valid, 1'b1);
      check_eq("latency", cyc - last_hs_cyc, 3);
      exp_o = (acc_v < 0) ? data_t'(0) : acc_v;
      check_eq("out_data", ifc.out_data, exp_o);
      check_eq("acc_clr_once", acc_clr_cnt, 1);
      for (int h = 0; h < hold; h++) begin
         step();
         check_eq("hold_valid", ifc.out_valid, 1'b1);
         check_eq("hold_data", ifc.out_data, exp_o);
         check_eq("hold_in_ready", ifc.in_ready, 1'b0);
      end
      ifc.out_ready = 1'b1;
      step();
      ifc.out_ready = 1'b0;
      check_eq("out_valid_drop", ifc.out_valid, 1'b0);
      check_eq("idle_after_out", busy, 1'b0);
   endtask

   initial begin
      data_t vec [N];
      data_t a;
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      accu         = '0;
      ifc.in_valid = 1'b0;
      ifc.in_data  = '0;
      ifc.out_ready = 1'b0;
      for (int i = 0; i < N; i++) w_m[i] = '0;
      b_m          = '0;
      cyc          = 0;
      vec_idx      = 0;
      last_hs_cyc  = 0;
      acc_clr_cnt  = 0;
      acc_clr_prev = 1'b0;

      repeat (2) @(negedge clk);
      check_all_zero("reset_outputs");
      rst_n = 1'b1;

      wr(0, 8'sd2);
      wr(1, -8'sd3);
      wr(2, 8'sd1);
      wr(3, 8'sd4);
      wr(4, 8'sd5);

      vec = '{8'sd1, 8'sd0, 8'sd0, 8'sd0};
      send_vector(vec, 1'b0, 8'sd23, 0, 1'b0, 0);
      vec = '{8'sd10, 8'sd20, -8'sd5, 8'sd7};
      send_vector(vec, 1'b0, -8'sd5, 0, 1'b0, 0);
      vec = '{8'sd3, -8'sd2, 8'sd9, 8'sd1};
      send_vector(vec, 1'b1, -8'sd128, 6, 1'b0, 0);
      vec = '{8'sd5, 8'sd5, 8'sd5, 8'sd5};
      send_vector(vec, 1'b0, 8'sd127, 0, 1'b1, 0);

      wr(5, 8'sd11);
      wr(7, -8'sd1);

      // Write and in_valid together in IDLE: the write wins and no vector starts.
      wr_en        = 1'b1;
      wr_addr      = AW'(3);
      wr_data      = 8'sd6;
      ifc.in_valid = 1'b1;
      step();
      wr_en        = 1'b0;
      ifc.in_valid = 1'b0;
      w_m[3]       = 8'sd6;
      check_eq("write_wins_busy", busy, 1'b0);
      check_eq("write_wins_clr", acc_clr, 1'b0);
      check_eq("write_wins_err", wr_err, 1'b0);

      vec = '{-8'sd7, 8'sd4, 8'sd2, -8'sd1};
      send_vector(vec, 1'b0, 8'sd0, 0, 1'b0, 2);
      vec = '{8'sd12, -8'sd3, 8'sd8, 8'sd100};
      send_vector(vec, 1'b0, 8'sd42, 1, 1'b0, 0);

      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) begin
            wr(int'($urandom_range(0, 7)), data_t'($urandom_range(0, 255)));
         end
         for (int i = 0; i < N; i++) vec[i] = data_t'($urandom_range(0, 255));
         a = data_t'($urandom_range(0, 255));
         send_vector(vec, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 4)), 1'b0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
